// File: rtl/temp_rgb_pwm.sv
// Temperature-to-RGB indicator: hysteretic COLD/MID/HOT zoning, a slow duty ramp
// toward the zone target, and a period-aligned PWM onto the R/G/B pins.
module temp_rgb_pwm #(
  parameter int          PWM_PERIOD = 100,
  parameter int          CNT_W      = 8,
  parameter int          HOT_C      = 30,
  parameter int          COLD_C     = 0,
  parameter int          HYST_C     = 1,
  parameter int          DUTY_HOT   = 80,
  parameter int          DUTY_MID   = 50,
  parameter int          DUTY_COLD  = 25,
  parameter logic [2:0]  RGB_HOT    = 3'b100,
  parameter logic [2:0]  RGB_MID    = 3'b010,
  parameter logic [2:0]  RGB_COLD   = 3'b001,
  parameter int          RAMP_DIV   = 1000
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             enable,
  input  logic             sample_valid,
  input  logic [15:0]      temp_data,
  input  logic [15:0]      manualSwitch,
  output logic             R,
  output logic             G,
  output logic             B,
  output logic [1:0]       zone,
  output logic [CNT_W-1:0] duty_level,
  output logic             ramp_busy
);

  localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_TC   = PRE_W'(RAMP_DIV - 1);
  localparam logic [CNT_W-1:0] PWM_TC   = CNT_W'(PWM_PERIOD - 1);
  localparam logic signed [9:0] HOT_TH    = 10'(HOT_C);
  localparam logic signed [9:0] HOT_EXIT  = 10'(HOT_C - HYST_C);
  localparam logic signed [9:0] COLD_TH   = 10'(COLD_C);
  localparam logic signed [9:0] COLD_EXIT = 10'(COLD_C + HYST_C);

  typedef enum logic [1:0] {
    ZONE_COLD = 2'b00,
    ZONE_MID  = 2'b01,
    ZONE_HOT  = 2'b10
  } zone_e;

  zone_e            zone_q, zone_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0] pwm_q, pwm_d;
  logic [CNT_W-1:0] duty_act_q, duty_act_d;
  logic [2:0]       mask_act_q, mask_act_d;
  logic [2:0]       rgb_q, rgb_d;

  logic [8:0]        src_t;
  logic signed [9:0] t_ext;
  logic              eval;
  logic [CNT_W-1:0]  duty_tgt;
  logic [2:0]        mask_tgt;
  logic              unused_lsbs;

  assign src_t       = enable ? temp_data[15:7] : manualSwitch[15:7];
  assign t_ext       = $signed({src_t[8], src_t});
  assign eval        = enable ? sample_valid : 1'b1;
  assign unused_lsbs = ^{temp_data[6:0], manualSwitch[6:0]};

  always_comb begin
    zone_d = zone_q;
    if (eval) begin
      case (zone_q)
        ZONE_MID: begin
          if (t_ext > HOT_TH)       zone_d = ZONE_HOT;
          else if (t_ext < COLD_TH) zone_d = ZONE_COLD;
        end
        ZONE_HOT: begin
          if (t_ext < COLD_TH)        zone_d = ZONE_COLD;
          else if (t_ext <= HOT_EXIT) zone_d = ZONE_MID;
        end
        ZONE_COLD: begin
          if (t_ext > HOT_TH)          zone_d = ZONE_HOT;
          else if (t_ext >= COLD_EXIT) zone_d = ZONE_MID;
        end
        default: zone_d = ZONE_MID;
      endcase
    end
  end

  always_comb begin
    duty_tgt = CNT_W'(DUTY_MID);
    mask_tgt = RGB_MID;
    case (zone_q)
      ZONE_HOT: begin
        duty_tgt = CNT_W'(DUTY_HOT);
        mask_tgt = RGB_HOT;
      end
      ZONE_COLD: begin
        duty_tgt = CNT_W'(DUTY_COLD);
        mask_tgt = RGB_COLD;
      end
      default: ;
    endcase
  end

  // The step at terminal count uses the current (pre-change) target; a zone
  // change in the same cycle only restarts the prescaler.
  always_comb begin
    pre_d  = pre_q + 1'b1;
    duty_d = duty_q;
    if (pre_q == PRE_TC) begin
      pre_d = '0;
      if (duty_q < duty_tgt)      duty_d = duty_q + 1'b1;
      else if (duty_q > duty_tgt) duty_d = duty_q - 1'b1;
    end
    if (zone_d != zone_q) pre_d = '0;
  end

  always_comb begin
    pwm_d      = (pwm_q == PWM_TC) ? '0 : pwm_q + 1'b1;
    duty_act_d = duty_act_q;
    mask_act_d = mask_act_q;
    if (pwm_q == PWM_TC) begin
      duty_act_d = duty_q;
      mask_act_d = mask_tgt;
    end
    rgb_d = mask_act_q & {3{pwm_q < duty_act_q}};
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      zone_q     <= ZONE_MID;
      pre_q      <= '0;
      duty_q     <= '0;
      pwm_q      <= '0;
      duty_act_q <= '0;
      mask_act_q <= '0;
      rgb_q      <= '0;
    end else begin
      zone_q     <= zone_d;
      pre_q      <= pre_d;
      duty_q     <= duty_d;
      pwm_q      <= pwm_d;
      duty_act_q <= duty_act_d;
      mask_act_q <= mask_act_d;
      rgb_q      <= rgb_d;
    end
  end

  assign R          = rgb_q[2];
  assign G          = rgb_q[1];
  assign B          = rgb_q[0];
  assign zone       = zone_q;
  assign duty_level = duty_q;
  assign ramp_busy  = (duty_q != duty_tgt);

endmodule
